// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: synchroniser, hold-count filter, rise/fall pulses and a sticky event register.
// Optional long-press detection is built when DEBOUNCE_LONGPRESS_EN is defined; otherwise long_press is tied to 0.
module multi_debouncer #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 16,
    parameter int LONG_HOLD   = 1024
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                evt_valid,
    output logic [CHANNELS-1:0] evt_rise,
    output logic [CHANNELS-1:0] evt_fall,
    input  logic                evt_ack,
    output logic [CHANNELS-1:0] long_press
);

    localparam int CW = $clog2(HOLD + 1);

    if (CHANNELS < 1 || SYNC_STAGES < 2 || HOLD < 1 || LONG_HOLD <= HOLD) begin : g_bad_param
        $error("multi_debouncer: illegal parameter combination");
    end

    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_long_press;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CW-1:0]          r_cnt;
            logic                   r_level;
            logic                   r_rise;
            logic                   r_fall;
            logic                   w_s;

            assign w_s = r_sync[SYNC_STAGES-1];

            // Any cycle where the synchronised input matches the level restarts the count.
            always_ff @(posedge clk) begin
                if (Reset) begin
                    r_sync  <= '0;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], in[gi]};
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (w_s == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CW'(HOLD - 1)) begin
                        r_level <= w_s;
                        r_cnt   <= '0;
                        r_rise  <= w_s;
                        r_fall  <= ~w_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_level[gi] = r_level;
            assign w_rise[gi]  = r_rise;
            assign w_fall[gi]  = r_fall;

`ifdef DEBOUNCE_LONGPRESS_EN
            localparam int LW = $clog2(LONG_HOLD + 1);
            logic [LW-1:0] r_lp_cnt;
            logic          r_lp;

            // Saturating at LONG_HOLD keeps the pulse to one per press.
            always_ff @(posedge clk) begin
                if (Reset) begin
                    r_lp_cnt <= '0;
                    r_lp     <= 1'b0;
                end else begin
                    r_lp <= r_level && (r_lp_cnt == LW'(LONG_HOLD - 1));
                    if (!r_level) begin
                        r_lp_cnt <= '0;
                    end else if (r_lp_cnt != LW'(LONG_HOLD)) begin
                        r_lp_cnt <= r_lp_cnt + 1'b1;
                    end
                end
            end

            assign w_long_press[gi] = r_lp;
`else
            assign w_long_press[gi] = 1'b0;
`endif
        end
    endgenerate

    logic [CHANNELS-1:0] r_evt_rise;
    logic [CHANNELS-1:0] r_evt_fall;
    logic                r_evt_valid;
    logic                w_ack;
    logic [CHANNELS-1:0] w_evt_rise_next;
    logic [CHANNELS-1:0] w_evt_fall_next;

    // New pulses are OR-ed in after the clear so a set in the ack cycle survives.
    assign w_ack           = evt_ack & r_evt_valid;
    assign w_evt_rise_next = (w_ack ? '0 : r_evt_rise) | w_rise;
    assign w_evt_fall_next = (w_ack ? '0 : r_evt_fall) | w_fall;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_evt_rise  <= '0;
            r_evt_fall  <= '0;
            r_evt_valid <= 1'b0;
        end else begin
            r_evt_rise  <= w_evt_rise_next;
            r_evt_fall  <= w_evt_fall_next;
            r_evt_valid <= |{w_evt_rise_next, w_evt_fall_next};
        end
    end

    assign level      = w_level;
    assign rise       = w_rise;
    assign fall       = w_fall;
    assign evt_rise   = r_evt_rise;
    assign evt_fall   = r_evt_fall;
    assign evt_valid  = r_evt_valid;
    assign long_press = w_long_press;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: a sample-history reference model checked every cycle plus literal checkpoints.
module tb_multi_debouncer;
    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int HOLD = 16;
    localparam int LH   = 64;
    localparam int D    = SYNC + HOLD - 1;
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [CH-1:0] LP_EXP = 4'b0001;
`else
    localparam logic [CH-1:0] LP_EXP = 4'b0000;
`endif

    logic          clk = 1'b0;
    logic          Reset;
    logic [CH-1:0] in;
    logic [CH-1:0] level, rise, fall, evt_rise, evt_fall, long_press;
    logic          evt_valid;
    logic          evt_ack;

    int checks = 0;
    int errors = 0;

    multi_debouncer #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .HOLD(HOLD), .LONG_HOLD(LH)
    ) dut (
        .clk(clk), .Reset(Reset), .in(in), .level(level), .rise(rise), .fall(fall),
        .evt_valid(evt_valid), .evt_rise(evt_rise), .evt_fall(evt_fall),
        .evt_ack(evt_ack), .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: level flips once the last HOLD synchronised samples all disagree with it.
    bit            m_init = 0;
    bit            m_hist [CH][D];
    logic [CH-1:0] m_level, m_rise, m_fall, m_er, m_ef, m_lp;
    logic          m_valid;
    int            m_run [CH];

    always @(posedge clk) begin
        if (Reset) begin
            m_init = 1;
            m_level = '0; m_rise = '0; m_fall = '0; m_er = '0; m_ef = '0; m_lp = '0; m_valid = 0;
            for (int c = 0; c < CH; c++) begin
                m_run[c] = 0;
                for (int j = 0; j < D; j++) m_hist[c][j] = 0;
            end
        end else begin
            bit ack_eff;
            ack_eff = evt_ack && m_valid;
            m_er = (ack_eff ? '0 : m_er) | m_rise;
            m_ef = (ack_eff ? '0 : m_ef) | m_fall;
            m_valid = (m_er != '0) || (m_ef != '0);
            for (int c = 0; c < CH; c++) begin
                bit all_diff;
                m_run[c] = m_level[c] ? m_run[c] + 1 : 0;
`ifdef DEBOUNCE_LONGPRESS_EN
                m_lp[c] = m_level[c] && (m_run[c] == LH);
`else
                m_lp[c] = 1'b0;
`endif
                all_diff = 1;
                for (int j = 0; j < HOLD; j++)
                    if (m_hist[c][SYNC-1+j] == m_level[c]) all_diff = 0;
                m_rise[c] = all_diff && !m_level[c];
                m_fall[c] = all_diff && m_level[c];
                if (all_diff) m_level[c] = ~m_level[c];
                for (int j = D - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
                m_hist[c][0] = in[c];
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("level",      32'(level),      32'(m_level));
            chk("rise",       32'(rise),       32'(m_rise));
            chk("fall",       32'(fall),       32'(m_fall));
            chk("evt_rise",   32'(evt_rise),   32'(m_er));
            chk("evt_fall",   32'(evt_fall),   32'(m_ef));
            chk("evt_valid",  32'(evt_valid),  32'(m_valid));
            chk("long_press", 32'(long_press), 32'(m_lp));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        Reset = 1'b1; in = '0; evt_ack = 1'b0;
        wait_cyc(3);
        chk("lit_reset_level", 32'(level), 32'h0);
        chk("lit_reset_valid", 32'(evt_valid), 32'h0);
        chk("lit_reset_rise", 32'(rise), 32'h0);
        Reset = 1'b0;
        wait_cyc(2);

        // clean press on channel 0
        in[0] = 1'b1;
        wait_cyc(17);
        chk("lit_press_edge17_level", 32'(level), 32'h0);
        wait_cyc(1);
        chk("lit_press_edge18_level", 32'(level), 32'h1);
        chk("lit_press_edge18_rise", 32'(rise), 32'h1);
        wait_cyc(1);
        chk("lit_press_rise_oneshot", 32'(rise), 32'h0);
        chk("lit_press_evt_rise", 32'(evt_rise), 32'h1);
        chk("lit_press_evt_valid", 32'(evt_valid), 32'h1);
        wait_cyc(21);

        // bounce on channel 1
        for (int k = 0; k < 12; k++) begin
            in[1] = ~in[1];
            for (int t = 0; t < 5; t++) begin
                wait_cyc(1);
                chk("lit_bounce_level1", 32'(level[1]), 32'h0);
            end
        end
        in[1] = 1'b1;
        wait_cyc(17);
        chk("lit_bounce_edge17_level", 32'(level), 32'h1);
        wait_cyc(1);
        chk("lit_bounce_edge18_rise", 32'(rise), 32'h2);
        chk("lit_bounce_edge18_level", 32'(level), 32'h3);
        wait_cyc(2);

        // ack racing a fall pulse on channel 2
        in[2] = 1'b1;
        wait_cyc(20);
        chk("lit_race_evt_rise", 32'(evt_rise), 32'h7);
        in[2] = 1'b0;
        wait_cyc(18);
        chk("lit_race_fall", 32'(fall), 32'h4);
        evt_ack = 1'b1;
        wait_cyc(1);
        evt_ack = 1'b0;
        chk("lit_race_evt_rise_clr", 32'(evt_rise), 32'h0);
        chk("lit_race_evt_fall_set", 32'(evt_fall), 32'h4);
        chk("lit_race_valid", 32'(evt_valid), 32'h1);
        evt_ack = 1'b1;
        wait_cyc(1);
        evt_ack = 1'b0;
        chk("lit_race_drained", 32'(evt_valid), 32'h0);
        chk("lit_race_evt_fall_clr", 32'(evt_fall), 32'h0);

        // simultaneous channels
        in = '0;
        wait_cyc(20);
        evt_ack = 1'b1;
        wait_cyc(1);
        evt_ack = 1'b0;
        chk("lit_multi_cleared", 32'(evt_valid), 32'h0);
        in = 4'b1111;
        wait_cyc(17);
        chk("lit_multi_edge17_level", 32'(level), 32'h0);
        wait_cyc(1);
        chk("lit_multi_rise", 32'(rise), 32'hF);
        chk("lit_multi_level", 32'(level), 32'hF);
        wait_cyc(5);
        in = 4'b0111;
        wait_cyc(18);
        chk("lit_multi_fall3", 32'(fall), 32'h8);
        chk("lit_multi_level3", 32'(level), 32'h7);
        wait_cyc(1);
        chk("lit_multi_evt_fall", 32'(evt_fall), 32'h8);
        chk("lit_multi_evt_rise", 32'(evt_rise), 32'hF);

        // reset in the middle of a count
        in = '0;
        wait_cyc(20);
        in = 4'b0001;
        wait_cyc(9);
        Reset = 1'b1;
        wait_cyc(1);
        Reset = 1'b0;
        chk("lit_rst_level", 32'(level), 32'h0);
        chk("lit_rst_rise", 32'(rise), 32'h0);
        chk("lit_rst_valid", 32'(evt_valid), 32'h0);
        chk("lit_rst_evt", 32'({evt_rise, evt_fall}), 32'h0);
        wait_cyc(17);
        chk("lit_rst_edge17_rise", 32'(rise), 32'h0);
        wait_cyc(1);
        chk("lit_rst_edge18_rise", 32'(rise), 32'h1);
        chk("lit_rst_edge18_level", 32'(level), 32'h1);

        // long press on channel 0
        wait_cyc(63);
        chk("lit_lp_before", 32'(long_press), 32'h0);
        wait_cyc(1);
        chk("lit_lp_pulse", 32'(long_press), 32'(LP_EXP));
        wait_cyc(1);
        chk("lit_lp_after", 32'(long_press), 32'h0);
        wait_cyc(80);
        chk("lit_lp_no_repeat", 32'(long_press), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
